// File: rtl/timer_ctrl.sv
// Countdown-timer control FSM: consumes one-cycle button pulses, holds an MM:SS
// preset and a BCD running count, and drives registered digits to the display.
module timer_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       pause_resume,
  input  logic       set_min,
  input  logic       set_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       done
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

  localparam logic [1:0] ST_SET   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Times are packed {min_tens, min_ones, sec_tens, sec_ones}.
  logic [15:0]   preset, preset_n;
  logic [15:0]   count, count_n;
  logic [PW-1:0] presc, presc_n;
  logic [1:0]    state_n;
  logic [15:0]   disp_n;
  logic [15:0]   dec;
  logic          tick;

  // Two-digit BCD increment, 59 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // One-second BCD decrement with borrows; floors at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else if (t[15:8] != 8'h00) begin
      r[7:0] = 8'h59;
      if (t[11:8] != 4'd0) begin
        r[11:8] = t[11:8] - 4'd1;
      end else begin
        r[15:12] = t[15:12] - 4'd1;
        r[11:8]  = 4'd9;
      end
    end else begin
      r = 16'h0000;
    end
    return r;
  endfunction

  always_comb begin
    state_n  = state;
    preset_n = preset;
    count_n  = count;
    presc_n  = presc;
    dec      = bcd_dec(count);
    tick     = (presc == LAST_TICK);

    case (state)
      ST_SET: begin
        // A start with a non-zero preset swallows any coincident set_* pulse.
        if (start_stop && preset != 16'h0000) begin
          count_n = preset;
          presc_n = '0;
          state_n = ST_RUN;
        end else begin
          if (set_min) preset_n[15:8] = bcd_inc(preset[15:8]);
          if (set_sec) preset_n[7:0]  = bcd_inc(preset[7:0]);
        end
      end
      ST_RUN: begin
        if (start_stop) begin
          state_n = ST_SET;
          count_n = 16'h0000;
          presc_n = '0;
        end else begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (tick) count_n = dec;
          // Reaching zero outranks a coincident pause.
          if (tick && dec == 16'h0000) state_n = ST_DONE;
          else if (pause_resume)       state_n = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_stop) begin
          state_n = ST_SET;
          count_n = 16'h0000;
          presc_n = '0;
        end else if (pause_resume) begin
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start_stop) begin
          state_n = ST_SET;
          count_n = 16'h0000;
          presc_n = '0;
        end
      end
      default: state_n = ST_SET;
    endcase

    case (state_n)
      ST_SET:            disp_n = preset_n;
      ST_RUN, ST_PAUSE:  disp_n = count_n;
      default:           disp_n = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SET;
      preset   <= 16'h0000;
      count    <= 16'h0000;
      presc    <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      preset   <= preset_n;
      count    <= count_n;
      presc    <= presc_n;
      min_tens <= disp_n[15:12];
      min_ones <= disp_n[11:8];
      sec_tens <= disp_n[7:4];
      sec_ones <= disp_n[3:0];
      done     <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with TICKS_PER_SEC=4: directed pulses push
// expected {state, done, MM:SS} words, a negedge monitor pops and compares them.
module tb_timer_ctrl;

  localparam int W = 19;

  logic       clk;
  logic       rst_n;
  logic       start_stop;
  logic       pause_resume;
  logic       set_min;
  logic       set_sec;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] state;
  logic       done;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks;
  int           errors;

  timer_ctrl #(.TICKS_PER_SEC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_stop   (start_stop),
    .pause_resume (pause_resume),
    .set_min      (set_min),
    .set_sec      (set_sec),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .state        (state),
    .done         (done)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the whole test must finish well inside this budget.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: outputs are stable at the falling edge; drain every pending expectation.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] expv;
    string        tag;
    while (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      tag  = tag_q.pop_front();
      act  = {state, done, min_tens, min_ones, sec_tens, sec_ones};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s: got st=%0d done=%0d %h%h:%h%h expected st=%0d done=%0d %h%h:%h%h",
                 tag, act[18:17], act[16], act[15:12], act[11:8], act[7:4], act[3:0],
                 expv[18:17], expv[16], expv[15:12], expv[11:8], expv[7:4], expv[3:0]);
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic ss, input logic pr, input logic sm, input logic se);
    start_stop   = ss;
    pause_resume = pr;
    set_min      = sm;
    set_sec      = se;
    @(posedge clk);
    #1;
    start_stop   = 1'b0;
    pause_resume = 1'b0;
    set_min      = 1'b0;
    set_sec      = 1'b0;
  endtask

  task automatic pulses(input int n, input logic ss, input logic pr, input logic sm, input logic se);
    repeat (n) pulse(ss, pr, sm, se);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic d,
                            input logic [15:0] mmss);
    exp_q.push_back({st, d, mmss});
    tag_q.push_back(tag);
  endtask

  task automatic check_now(input string tag, input logic [1:0] st, input logic d,
                           input logic [15:0] mmss);
    logic [W-1:0] act;
    logic [W-1:0] expv;
    act  = {state, done, min_tens, min_ones, sec_tens, sec_ones};
    expv = {st, d, mmss};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got st=%0d done=%0d %h%h:%h%h expected st=%0d done=%0d %h%h:%h%h",
               tag, act[18:17], act[16], act[15:12], act[11:8], act[7:4], act[3:0],
               expv[18:17], expv[16], expv[15:12], expv[11:8], expv[7:4], expv[3:0]);
    end
  endtask

  task automatic drain_wait(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_wait: %0d expectations still pending after %0d cycles",
               exp_q.size(), max_cycles);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    start_stop   = 1'b0;
    pause_resume = 1'b0;
    set_min      = 1'b0;
    set_sec      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", 2'd0, 1'b0, 16'h0000);
    expect_out("reset", 2'd0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    idle(1);
    expect_out("after_reset", 2'd0, 1'b0, 16'h0000);

    // Preset editing and wraps
    pulses(2, 0, 0, 1, 0);
    pulses(3, 0, 0, 0, 1);
    expect_out("preset_0203", 2'd0, 1'b0, 16'h0203);
    pulses(56, 0, 0, 0, 1);
    expect_out("preset_0259", 2'd0, 1'b0, 16'h0259);
    pulse(0, 0, 0, 1);
    expect_out("sec_wrap_nocarry", 2'd0, 1'b0, 16'h0200);

    // Short countdown to DONE
    pulses(58, 0, 0, 1, 0);
    expect_out("min_wrap", 2'd0, 1'b0, 16'h0000);
    pulses(2, 0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    expect_out("run_start", 2'd1, 1'b0, 16'h0002);
    idle(3);
    expect_out("run_pre_tick", 2'd1, 1'b0, 16'h0002);
    idle(1);
    expect_out("run_first_dec", 2'd1, 1'b0, 16'h0001);
    idle(3);
    expect_out("run_hold", 2'd1, 1'b0, 16'h0001);
    idle(1);
    expect_out("done_reached", 2'd3, 1'b1, 16'h0000);
    pulse(1, 0, 0, 0);
    expect_out("done_to_set", 2'd0, 1'b0, 16'h0002);

    // Minute borrow
    pulse(0, 0, 1, 0);
    pulses(58, 0, 0, 0, 1);
    expect_out("preset_0100", 2'd0, 1'b0, 16'h0100);
    pulse(1, 0, 0, 0);
    expect_out("run_0100", 2'd1, 1'b0, 16'h0100);
    idle(4);
    expect_out("min_borrow", 2'd1, 1'b0, 16'h0059);
    pulse(1, 0, 0, 0);
    expect_out("abort_keeps_preset", 2'd0, 1'b0, 16'h0100);

    // Pause keeps the partial second
    pulses(59, 0, 0, 1, 0);
    pulses(3, 0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    idle(1);
    pulse(0, 1, 0, 0);
    expect_out("paused", 2'd2, 1'b0, 16'h0003);
    idle(20);
    expect_out("pause_frozen", 2'd2, 1'b0, 16'h0003);
    pulse(0, 1, 0, 0);
    expect_out("resumed", 2'd1, 1'b0, 16'h0003);
    idle(1);
    expect_out("resume_plus1", 2'd1, 1'b0, 16'h0003);
    idle(1);
    expect_out("resume_plus2_dec", 2'd1, 1'b0, 16'h0002);
    idle(3);
    pulse(0, 1, 0, 0);
    expect_out("tick_with_pause", 2'd2, 1'b0, 16'h0001);
    pulse(0, 1, 0, 0);
    idle(3);
    pulse(0, 1, 0, 0);
    expect_out("done_beats_pause", 2'd3, 1'b1, 16'h0000);
    pulse(0, 1, 1, 1);
    expect_out("done_ignores", 2'd3, 1'b1, 16'h0000);
    pulse(1, 0, 0, 0);
    expect_out("done_exit", 2'd0, 1'b0, 16'h0003);

    // Simultaneous-event priorities
    pulses(57, 0, 0, 0, 1);
    expect_out("preset_zero", 2'd0, 1'b0, 16'h0000);
    pulse(1, 0, 0, 0);
    expect_out("zero_start_ignored", 2'd0, 1'b0, 16'h0000);
    pulses(5, 0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    expect_out("run_0005", 2'd1, 1'b0, 16'h0005);
    idle(3);
    pulse(1, 0, 0, 0);
    expect_out("stop_on_tick", 2'd0, 1'b0, 16'h0005);
    pulse(1, 0, 1, 0);
    expect_out("start_beats_setmin", 2'd1, 1'b0, 16'h0005);
    pulse(1, 0, 0, 0);
    expect_out("setmin_dropped", 2'd0, 1'b0, 16'h0005);
    pulse(0, 0, 1, 1);
    expect_out("set_both", 2'd0, 1'b0, 16'h0106);
    pulse(0, 1, 0, 0);
    expect_out("set_ignores_pause", 2'd0, 1'b0, 16'h0106);

    // Asynchronous reset mid-run
    pulse(1, 0, 0, 0);
    expect_out("run_0106", 2'd1, 1'b0, 16'h0106);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_immediate", 2'd0, 1'b0, 16'h0000);
    expect_out("async_reset", 2'd0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_out("reset_release", 2'd0, 1'b0, 16'h0000);
    idle(1);
    expect_out("post_reset_idle", 2'd0, 1'b0, 16'h0000);
    pulse(0, 0, 0, 1);
    expect_out("post_reset_preset", 2'd0, 1'b0, 16'h0001);

    drain_wait(4);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Countdown-timer control FSM. Sits directly downstream of the button one-pulse stage and consumes its four single-cycle pulses: start_stop, pause_resume, set_min, set_sec.
- Holds a preset time (MM:SS) and a running count, decrements once per second from an internal prescaler, and drives BCD digits to the 7-segment display stage.

Parameters:
- TICKS_PER_SEC, default 100_000_000: clk cycles per counted second; the bench overrides it to 4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_stop  in  1  one-cycle pulse: start countdown, or abort back to SET.
- pause_resume  in  1  one-cycle pulse: toggle RUN/PAUSE.
- set_min  in  1  one-cycle pulse: increment preset minutes (SET only).
- set_sec  in  1  one-cycle pulse: increment preset seconds (SET only).
- min_tens  out  4  BCD minutes tens digit, 0..5.
- min_ones  out  4  BCD minutes ones digit, 0..9.
- sec_tens  out  4  BCD seconds tens digit, 0..5.
- sec_ones  out  4  BCD seconds ones digit, 0..9.
- state  out  2  SET=0, RUN=1, PAUSE=2, DONE=3.
- done  out  1  high while state==DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=SET; preset=00:00; count=00:00; prescaler=0.
  - All outputs 0.
- Registers and latency:
  - All outputs are registered.
  - Each input pulse takes effect on the edge where it is sampled high, so the result is visible the following cycle.
  - Inputs are assumed one cycle wide. A level held high is treated as one event per cycle; it is not debounced here.
- Display:
  - SET: digits show preset.
  - RUN, PAUSE: digits show count.
  - DONE: digits show 00:00.
- Time is kept internally as BCD digit pairs. Minutes and seconds each range 00..59.
- SET:
  - set_min: preset minutes +1, wrapping 59->00.
  - set_sec: preset seconds +1, wrapping 59->00. Seconds never carry into minutes.
  - set_min and set_sec in the same cycle: both fields increment.
  - start_stop with preset!=00:00: count<=preset, prescaler<=0, state<=RUN.
  - start_stop with preset==00:00: ignored.
  - pause_resume: ignored.
- RUN:
  - prescaler counts 0..TICKS_PER_SEC-1 and wraps. tick = (prescaler==TICKS_PER_SEC-1).
  - On tick, count decrements one second:
    - sec_ones 0 borrows from sec_tens.
    - seconds 00 -> 59 with minutes -1.
  - If the decrement yields 00:00, state<=DONE on that same edge; done=1 next cycle.
  - First decrement occurs TICKS_PER_SEC cycles after entering RUN.
  - pause_resume: state<=PAUSE.
  - start_stop: state<=SET; count discarded; preset retained.
  - set_min/set_sec: ignored.
- PAUSE:
  - prescaler and count frozen.
  - pause_resume: state<=RUN; prescaler resumes from its held value, with no reset of the partial second.
  - start_stop: state<=SET.
  - set_min/set_sec: ignored.
- DONE:
  - done=1.
  - start_stop: state<=SET, done<=0, preset unchanged.
  - All other inputs ignored.
- Simultaneous events:
  - Priority is start_stop > pause_resume > set_*.
  - RUN, tick with pause_resume: decrement applied, then state<=PAUSE. If the decrement hits 00:00, DONE wins over PAUSE.
  - RUN, tick with start_stop: go to SET; tick discarded.
  - SET, start_stop with set_*: start wins; the preset increment is dropped; count loads the pre-increment preset.
- Reset mid-operation: immediate return to reset values from any state.
- Invariants:
  - No digit ever exceeds its BCD range.
  - count never underflows below 00:00.

Test Plan (TICKS_PER_SEC=4):
1. Reset, then set_min x2 and set_sec x3 pulses -> digits 0,2,0,3; state=0. Then set_sec x57 -> seconds wrap to 00, minutes stay 02.
2. Preset 00:02, start_stop -> state=1, display 00:02. After 4 cycles display 00:01. After 4 more, display 00:00, state=3, done=1. start_stop -> state=0, display 00:02, done=0.
3. Preset 01:00, start, wait 4 cycles -> display 00:59, verifying the minute borrow.
4. Preset 00:03, start, pause_resume after 2 cycles -> state=2, display frozen at 00:03 for 20 cycles. pause_resume -> first decrement to 00:02 exactly 2 cycles later.
5. Preset 00:00, start_stop -> state stays 0. In RUN, start_stop coincident with tick -> state=0, display shows preset. In SET, start_stop coincident with set_min -> RUN, count equals old preset.
6. Assert rst_n=0 mid-RUN, asynchronously between edges -> outputs all 0 before the next clk edge. After release, state=0 and preset=00:00.
